// File: rtl/sr_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : sr_control_mc
// Purpose  : Multi-cycle control unit for a schoolRISCV-class RV32I core.
//            Decodes ALU, immediate, LUI, branch, load, store and (optionally)
//            M-extension MUL instructions. Sequences data-memory wait states
//            through a req/ack handshake and a fixed-latency multiplier
//            through an internal down-counter. It owns PC advance, so the
//            datapath keeps the instruction fields stable until pcWrite_o.
//
// Ports    : clk            - clock
//            rst            - asynchronous reset, active high
//            instrValid_i   - cmd* fields hold a valid instruction
//            cmdOp_i[6:0]   - opcode
//            cmdF3_i[2:0]   - funct3
//            cmdF7_i[6:0]   - funct7
//            aluZero_i      - ALU result == 0
//            aluLt_i        - signed rs1 < rs2
//            memAck_i       - data memory completes the access this cycle
//            pcWrite_o      - update PC this cycle
//            pcSrc_o        - 1 = branch target, 0 = PC+4 (valid with pcWrite_o)
//            regWrite_o     - write rd
//            aluSrc_o[1:0]  - SRC_B_* operand-B select
//            aluControl_o[3:0] - ALU_* operation
//            wdSrc_o[1:0]   - 00 ALU, 01 U-imm, 10 load data, 11 multiplier
//            memReq_o       - data memory request
//            memWe_o        - 1 = store
//            memSize_o[1:0] - 00 byte, 01 half, 10 word
//            memUnsigned_o  - zero-extend load data
//            mulStart_o     - one-cycle pulse launching the multiplier
//            stall_o        - in MEM or MUL state
//            illegal_o      - one-cycle pulse on an undecodable instruction
//            halted_o       - in HALT state
//
// Revision : 1.0 - initial multi-cycle release
// ============================================================================
module sr_control_mc #(
    parameter int ENABLE_LOAD = 1,  // 1 = decode LB/LH/LW/LBU/LHU
    parameter int ENABLE_MUL  = 1,  // 1 = decode MUL
    parameter int MUL_CYCLES  = 4   // multiplier latency, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instrValid_i,
    input  logic [6:0] cmdOp_i,
    input  logic [2:0] cmdF3_i,
    input  logic [6:0] cmdF7_i,
    input  logic       aluZero_i,
    input  logic       aluLt_i,
    input  logic       memAck_i,
    output logic       pcWrite_o,
    output logic       pcSrc_o,
    output logic       regWrite_o,
    output logic [1:0] aluSrc_o,
    output logic [3:0] aluControl_o,
    output logic [1:0] wdSrc_o,
    output logic       memReq_o,
    output logic       memWe_o,
    output logic [1:0] memSize_o,
    output logic       memUnsigned_o,
    output logic       mulStart_o,
    output logic       stall_o,
    output logic       illegal_o,
    output logic       halted_o
);

    // ------------------------------------------------------------------------
    // Datapath encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] SRC_B_RD2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM_I = 2'b01;
    localparam logic [1:0] SRC_B_IMM_S = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_UIMM = 2'b01;
    localparam logic [1:0] WD_LOAD = 2'b10;
    localparam logic [1:0] WD_MUL  = 2'b11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    // Counter preload: the completion cycle is the one where the counter
    // reads zero, so a latency of N needs N-1 decrement cycles after start.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_EXEC = 2'd0,
        S_MEM  = 2'd1,
        S_MUL  = 2'd2,
        S_HALT = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        K_ILL   = 3'd0,
        K_ALU   = 3'd1,
        K_ALUI  = 3'd2,
        K_LUI   = 3'd3,
        K_BR    = 3'd4,
        K_LOAD  = 3'd5,
        K_STORE = 3'd6,
        K_MUL   = 3'd7
    } kind_e;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    kind_e      w_kind;
    logic [3:0] w_aluOp;
    logic       w_brTaken;
    logic       w_isLoad;

    // ------------------------------------------------------------------------
    // Instruction decode (pure function of the held instruction fields)
    // ------------------------------------------------------------------------
    always_comb begin
        w_kind  = K_ILL;
        w_aluOp = ALU_ADD;
        case (cmdOp_i)
            OP_R: begin
                if (cmdF7_i == F7_BASE) begin
                    w_kind = K_ALU;
                    case (cmdF3_i)
                        3'b000:  w_aluOp = ALU_ADD;
                        3'b111:  w_aluOp = ALU_AND;
                        3'b110:  w_aluOp = ALU_OR;
                        3'b100:  w_aluOp = ALU_XOR;
                        3'b001:  w_aluOp = ALU_SLL;
                        3'b101:  w_aluOp = ALU_SRL;
                        3'b011:  w_aluOp = ALU_SLTU;
                        default: w_kind  = K_ILL;
                    endcase
                end else if (cmdF7_i == F7_ALT && cmdF3_i == 3'b000) begin
                    w_kind  = K_ALU;
                    w_aluOp = ALU_SUB;
                end else if (cmdF7_i == F7_MULD && cmdF3_i == 3'b000 && ENABLE_MUL != 0) begin
                    w_kind = K_MUL;
                end
            end
            OP_IMM: begin
                w_kind = K_ALUI;
                case (cmdF3_i)
                    3'b000: w_aluOp = ALU_ADD;
                    3'b111: w_aluOp = ALU_AND;
                    3'b110: w_aluOp = ALU_OR;
                    3'b100: w_aluOp = ALU_XOR;
                    // Shift-immediates carry funct7 in imm[11:5]; only the
                    // logical forms are supported.
                    3'b001: begin
                        w_aluOp = ALU_SLL;
                        if (cmdF7_i != F7_BASE) w_kind = K_ILL;
                    end
                    3'b101: begin
                        w_aluOp = ALU_SRL;
                        if (cmdF7_i != F7_BASE) w_kind = K_ILL;
                    end
                    default: w_kind = K_ILL;
                endcase
            end
            OP_LUI: begin
                w_kind = K_LUI;
            end
            OP_BRANCH: begin
                case (cmdF3_i)
                    3'b000, 3'b001, 3'b100, 3'b101: w_kind = K_BR;
                    default:                        w_kind = K_ILL;
                endcase
            end
            OP_LOAD: begin
                if (ENABLE_LOAD != 0) begin
                    case (cmdF3_i)
                        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_kind = K_LOAD;
                        default:                                w_kind = K_ILL;
                    endcase
                end
            end
            OP_STORE: begin
                case (cmdF3_i)
                    3'b000, 3'b001, 3'b010: w_kind = K_STORE;
                    default:                w_kind = K_ILL;
                endcase
            end
            default: w_kind = K_ILL;
        endcase
    end

    // Branch condition: funct3[2] selects less-than vs equality, funct3[0]
    // inverts the sense.
    always_comb begin
        case (cmdF3_i)
            3'b000:  w_brTaken =  aluZero_i;
            3'b001:  w_brTaken = ~aluZero_i;
            3'b100:  w_brTaken =  aluLt_i;
            3'b101:  w_brTaken = ~aluLt_i;
            default: w_brTaken = 1'b0;
        endcase
    end

    assign w_isLoad = (w_kind == K_LOAD);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EXEC;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pcWrite_o     = 1'b0;
        pcSrc_o       = 1'b0;
        regWrite_o    = 1'b0;
        aluSrc_o      = SRC_B_RD2;
        aluControl_o  = ALU_ADD;
        wdSrc_o       = WD_ALU;
        memReq_o      = 1'b0;
        memWe_o       = 1'b0;
        memSize_o     = 2'b00;
        memUnsigned_o = 1'b0;
        mulStart_o    = 1'b0;
        stall_o       = 1'b0;
        illegal_o     = 1'b0;
        halted_o      = 1'b0;

        // Outputs are gated by rst so an in-flight memory request is
        // withdrawn the moment reset is asserted, not at the next edge.
        if (!rst) begin
            case (state_q)
                S_EXEC: begin
                    if (instrValid_i) begin
                        case (w_kind)
                            K_ALU: begin
                                regWrite_o   = 1'b1;
                                pcWrite_o    = 1'b1;
                                aluControl_o = w_aluOp;
                            end
                            K_ALUI: begin
                                regWrite_o   = 1'b1;
                                pcWrite_o    = 1'b1;
                                aluSrc_o     = SRC_B_IMM_I;
                                aluControl_o = w_aluOp;
                            end
                            K_LUI: begin
                                regWrite_o = 1'b1;
                                pcWrite_o  = 1'b1;
                                wdSrc_o    = WD_UIMM;
                            end
                            K_BR: begin
                                aluControl_o = ALU_SUB;
                                pcWrite_o    = 1'b1;
                                pcSrc_o      = w_brTaken;
                            end
                            K_LOAD, K_STORE: begin
                                memReq_o      = 1'b1;
                                memWe_o       = ~w_isLoad;
                                memSize_o     = cmdF3_i[1:0];
                                memUnsigned_o = w_isLoad & cmdF3_i[2];
                                aluSrc_o      = w_isLoad ? SRC_B_IMM_I : SRC_B_IMM_S;
                                if (memAck_i) begin
                                    // Zero-wait access completes in place.
                                    pcWrite_o = 1'b1;
                                    if (w_isLoad) begin
                                        regWrite_o = 1'b1;
                                        wdSrc_o    = WD_LOAD;
                                    end
                                end else begin
                                    state_d = S_MEM;
                                end
                            end
                            K_MUL: begin
                                mulStart_o = 1'b1;
                                cnt_d      = MUL_LOAD;
                                state_d    = S_MUL;
                            end
                            default: begin
                                illegal_o = 1'b1;
                                state_d   = S_HALT;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    // Instruction fields are held, so re-decoding them keeps
                    // address/size/we controls stable across wait states.
                    stall_o       = 1'b1;
                    memReq_o      = 1'b1;
                    memWe_o       = ~w_isLoad;
                    memSize_o     = cmdF3_i[1:0];
                    memUnsigned_o = w_isLoad & cmdF3_i[2];
                    aluSrc_o      = w_isLoad ? SRC_B_IMM_I : SRC_B_IMM_S;
                    if (memAck_i) begin
                        pcWrite_o = 1'b1;
                        if (w_isLoad) begin
                            regWrite_o = 1'b1;
                            wdSrc_o    = WD_LOAD;
                        end
                        state_d = S_EXEC;
                    end
                end
                S_MUL: begin
                    stall_o = 1'b1;
                    if (cnt_q == 4'd0) begin
                        regWrite_o = 1'b1;
                        wdSrc_o    = WD_MUL;
                        pcWrite_o  = 1'b1;
                        state_d    = S_EXEC;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_HALT: begin
                    halted_o = 1'b1;
                end
                default: begin
                    state_d = S_EXEC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
